// File: rtl/seq_detect_ctrl_if.sv
// Config port of the serial pattern detector: pattern/target write with valid/ready.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;

  modport master (output cfg_valid, cfg_pattern, cfg_target, input cfg_ready);
  modport slave  (input cfg_valid, cfg_pattern, cfg_target, output cfg_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: arm, detect overlapping matches, count, retire on
// target or abort.
module seq_detect_ctrl #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rstn,
  seq_detect_ctrl_if.slave cfg,
  input  logic             start,
  input  logic             abort,
  input  logic             seqin,
  input  logic             seqin_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [PAT_W-1:0] win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             match_q, match_d;
  logic             done_q, done_d;

  logic [PAT_W-1:0]  win_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;

  // An abort in the same cycle as a completing bit suppresses the hit entirely.
  assign win_shift = {win_q[PAT_W-2:0], seqin};
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign hit       = (state_q == S_ARMED) && seqin_valid && !abort &&
                     (fill_inc == FILL_FULL) && (win_shift == pat_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pat_q   <= RESET_PAT;
      tgt_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)
          state_d = S_IDLE;
        else if (hit && (tgt_q != '0) && (cnt_inc == tgt_q))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pat_d   = pat_q;
    tgt_d   = tgt_q;
    win_d   = win_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = hit;
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid) begin
          pat_d = cfg.cfg_pattern;
          tgt_d = cfg.cfg_target;
        end
        if (start) begin
          win_d  = '0;
          fill_d = '0;
          cnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (!abort && seqin_valid) begin
          win_d  = win_shift;
          fill_d = fill_inc;
          if (hit) cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign busy          = busy_q;
  assign match         = match_q;
  assign match_count   = cnt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a bit-history model checked every cycle, plus literal pins.
module tb_seq_detect_ctrl;
  localparam int PW = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0, abort = 1'b0, seqin = 1'b0, seqin_valid = 1'b0;
  logic busy, match, done;
  logic [CW-1:0] match_count;

  seq_detect_ctrl_if #(.PAT_W(PW), .CNT_W(CW)) cif ();

  seq_detect_ctrl #(.PAT_W(PW), .CNT_W(CW), .RESET_PAT(4'b1011)) dut (
    .clk(clk), .rstn(rstn), .cfg(cif.slave), .start(start), .abort(abort),
    .seqin(seqin), .seqin_valid(seqin_valid), .busy(busy), .match(match),
    .match_count(match_count), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a run is a list of accepted bits; a hit is the last PW bits equal to the pattern.
  bit          m_run, m_fin, e_match, e_done;
  logic [PW-1:0] m_pat;
  int          m_tgt, m_cnt;
  bit          m_hist[$];

  function automatic int tail_val();
    int v = 0;
    int n = m_hist.size();
    for (int k = 0; k < PW; k++) v = (v << 1) | int'(m_hist[n-PW+k]);
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_fin = 0; e_match = 0; e_done = 0;
      m_pat = 4'b1011; m_tgt = 0; m_cnt = 0;
      m_hist.delete();
    end else begin
      e_match = 0; e_done = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_run) begin
        if (abort) m_run = 0;
        else if (seqin_valid) begin
          m_hist.push_back(seqin);
          if (m_hist.size() >= PW && tail_val() == int'(m_pat)) begin
            e_match = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_tgt != 0 && m_cnt == m_tgt) begin
              m_run = 0; m_fin = 1; e_done = 1;
            end
          end
        end
      end else begin
        if (cif.cfg_valid) begin
          m_pat = cif.cfg_pattern;
          m_tgt = int'(cif.cfg_target);
        end
        if (start) begin
          m_run = 1; m_cnt = 0;
          m_hist.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready", 32'(cif.cfg_ready), 32'(!(m_run || m_fin)));
      chk("busy",      32'(busy),          32'(m_run || m_fin));
      chk("match",     32'(match),         32'(e_match));
      chk("done",      32'(done),          32'(e_done));
      chk("count",     32'(match_count),   32'(m_cnt));
    end
  end

  task automatic drive(input bit cv, input logic [PW-1:0] cp, input logic [CW-1:0] ct,
                       input bit st, input bit ab, input bit sv, input bit sb);
    cif.cfg_valid = cv; cif.cfg_pattern = cp; cif.cfg_target = ct;
    start = st; abort = ab; seqin_valid = sv; seqin = sb;
    @(negedge clk);
  endtask

  task automatic idle();                  drive(0, '0, '0, 0, 0, 0, 0); endtask
  task automatic go();                    drive(0, '0, '0, 1, 0, 0, 0); endtask
  task automatic stop();                  drive(0, '0, '0, 0, 1, 0, 0); endtask
  task automatic bitin(input bit b);      drive(0, '0, '0, 0, 0, 1, b); endtask
  task automatic cfgw(input logic [PW-1:0] p, input logic [CW-1:0] t, input bit st);
    drive(1, p, t, st, 0, 0, 0);
  endtask

  initial begin
    cif.cfg_valid = 0; cif.cfg_pattern = '0; cif.cfg_target = '0;
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cif.cfg_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_match", 32'(match), 0);
    @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;

    // T1: reset pattern 1011, target 0
    go();
    bitin(1); bitin(0); bitin(1);
    chk("t1_nomatch", 32'(match), 0);
    bitin(1);
    chk("t1_match", 32'(match), 1);
    chk("t1_count", 32'(match_count), 1);
    idle();
    chk("t1_pulse", 32'(match), 0);
    stop();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_hold_cnt",  32'(match_count), 1);

    // T2: overlap, target 2
    cfgw(4'b1011, 2'd2, 0);
    go();
    bitin(1); bitin(0); bitin(1); bitin(1);
    chk("t2_m1", 32'(match), 1);
    bitin(0); bitin(1);
    chk("t2_gap", 32'(match), 0);
    bitin(1);
    chk("t2_m2",   32'(match), 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_cnt",  32'(match_count), 2);
    idle();
    chk("t2_idle", 32'(busy), 0);
    chk("t2_done_off", 32'(done), 0);

    // T3: valid gaps inside the pattern
    go();
    bitin(1); idle(); bitin(0); idle(); idle();
    chk("t3_frozen", 32'(match_count), 0);
    bitin(1); bitin(1);
    chk("t3_match", 32'(match), 1);
    chk("t3_cnt",   32'(match_count), 1);
    stop();

    // T4: abort together with the completing bit
    go();
    bitin(1); bitin(0); bitin(1);
    drive(0, '0, '0, 0, 1, 1, 1);
    chk("t4_match", 32'(match), 0);
    chk("t4_cnt",   32'(match_count), 0);
    chk("t4_busy",  32'(busy), 0);
    chk("t4_done",  32'(done), 0);

    // T5: config ignored while armed, same-cycle config+start honoured
    go();
    chk("t5_ready_armed", 32'(cif.cfg_ready), 0);
    cfgw(4'b0000, 2'd1, 0);
    bitin(1); bitin(0); bitin(1); bitin(1);
    chk("t5_oldpat", 32'(match), 1);
    chk("t5_nodone", 32'(done), 0);
    stop();
    cfgw(4'b0110, 2'd1, 1);
    bitin(0); bitin(1); bitin(1); bitin(0);
    chk("t5_newpat", 32'(match), 1);
    chk("t5_done",   32'(done), 1);
    idle();

    // T6: target 0, saturating count, then reset mid-run
    cfgw(4'b1111, 2'd0, 1);
    for (int i = 0; i < 8; i++) bitin(1);
    chk("t6_sat",   32'(match_count), 3);
    chk("t6_match", 32'(match), 1);
    chk("t6_busy",  32'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy), 0);
    chk("t6_rst_cnt",   32'(match_count), 0);
    chk("t6_rst_ready", 32'(cif.cfg_ready), 1);
    chk("t6_rst_match", 32'(match), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    go();
    bitin(1); bitin(1); bitin(1); bitin(1);
    chk("t6_cfg_lost", 32'(match), 0);
    stop();
    go();
    bitin(1); bitin(0); bitin(1); bitin(1);
    chk("t6_resetpat", 32'(match), 1);
    chk("t6_notdone",  32'(done), 0);
    idle(); idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
